// File: rtl/ofs_fim_emif_avmm_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ofs_fim_emif_avmm_arb
//  Description : Two-requester round-robin arbiter sharing one EMIF Avalon-MM
//                channel. Commands are forwarded with zero added latency,
//                a write burst keeps the grant until its last beat, and a
//                tag FIFO routes in-order read data back to the issuing port
//                with one registered cycle.
//                Optional macro EMIF_ARB_RD_ERR_CHK_EN builds the sticky
//                unexpected-read-data flag and simulation checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module ofs_fim_emif_avmm_arb #(
    parameter int ADDR_WIDTH       = 27,
    parameter int DATA_WIDTH       = 576,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int BYTEENABLE_WIDTH = 72,
    parameter int RD_FIFO_DEPTH    = 16
) (
    input  logic                        mem_clk,
    input  logic                        mem_rst_n,

    input  logic                        s0_read,
    input  logic                        s0_write,
    input  logic [ADDR_WIDTH-1:0]       s0_address,
    input  logic [BURSTCOUNT_WIDTH-1:0] s0_burstcount,
    input  logic [DATA_WIDTH-1:0]       s0_writedata,
    input  logic [BYTEENABLE_WIDTH-1:0] s0_byteenable,
    output logic                        s0_waitrequest,
    output logic [DATA_WIDTH-1:0]       s0_readdata,
    output logic                        s0_readdatavalid,

    input  logic                        s1_read,
    input  logic                        s1_write,
    input  logic [ADDR_WIDTH-1:0]       s1_address,
    input  logic [BURSTCOUNT_WIDTH-1:0] s1_burstcount,
    input  logic [DATA_WIDTH-1:0]       s1_writedata,
    input  logic [BYTEENABLE_WIDTH-1:0] s1_byteenable,
    output logic                        s1_waitrequest,
    output logic [DATA_WIDTH-1:0]       s1_readdata,
    output logic                        s1_readdatavalid,

    output logic                        m_read,
    output logic                        m_write,
    output logic [ADDR_WIDTH-1:0]       m_address,
    output logic [BURSTCOUNT_WIDTH-1:0] m_burstcount,
    output logic [DATA_WIDTH-1:0]       m_writedata,
    output logic [BYTEENABLE_WIDTH-1:0] m_byteenable,
    input  logic                        m_waitrequest,
    input  logic [DATA_WIDTH-1:0]       m_readdata,
    input  logic                        m_readdatavalid,

    output logic                        err_rd_unexp
);

    localparam int PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]            FIFO_FULL_CNT = CNT_W'(RD_FIFO_DEPTH);
    localparam logic [BURSTCOUNT_WIDTH-1:0] BC_ONE        = BURSTCOUNT_WIDTH'(1);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WR_BURST = 1'b1;

    // Arbitration state
    logic [0:0]                  state, state_nxt;
    logic                        last_grant, last_grant_nxt;
    logic                        wr_owner, wr_owner_nxt;
    logic [BURSTCOUNT_WIDTH-1:0] wr_left, wr_left_nxt;

    // Grant and command selection
    logic                        req0, req1;
    logic                        gnt_valid, gnt_port;
    logic                        sel_read, sel_write;
    logic [BURSTCOUNT_WIDTH-1:0] sel_bc, sel_bc_eff;
    logic                        accept;

    // Read tag FIFO: {owner port, beat count}
    logic [BURSTCOUNT_WIDTH:0]   fifo_mem [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;
    logic [CNT_W-1:0]            fifo_cnt;
    logic                        fifo_full, fifo_empty;
    logic                        push, pop;
    logic                        head_port;
    logic [BURSTCOUNT_WIDTH-1:0] head_bc;
    logic [BURSTCOUNT_WIDTH-1:0] rd_cnt;
    logic                        route_valid;

    assign fifo_full   = (fifo_cnt == FIFO_FULL_CNT);
    assign fifo_empty  = (fifo_cnt == '0);
    assign head_port   = fifo_mem[rd_ptr][BURSTCOUNT_WIDTH];
    assign head_bc     = fifo_mem[rd_ptr][BURSTCOUNT_WIDTH-1:0];
    assign route_valid = m_readdatavalid & ~fifo_empty;

    // Grant selection: burst owner holds the channel, otherwise round-robin
    // among ports whose request can be taken (reads need FIFO space).
    always_comb begin
        req0      = s0_write | (s0_read & ~fifo_full);
        req1      = s1_write | (s1_read & ~fifo_full);
        gnt_valid = 1'b0;
        gnt_port  = 1'b0;
        if (state == WR_BURST) begin
            gnt_valid = 1'b1;
            gnt_port  = wr_owner;
        end else if (req0 && req1) begin
            gnt_valid = 1'b1;
            gnt_port  = ~last_grant;
        end else if (req0) begin
            gnt_valid = 1'b1;
            gnt_port  = 1'b0;
        end else if (req1) begin
            gnt_valid = 1'b1;
            gnt_port  = 1'b1;
        end
    end

    // Output decode: pass the granted command straight to the EMIF.
    // A write wins over a simultaneous read; reads are never forwarded
    // while a write burst owns the channel.
    always_comb begin
        sel_read       = gnt_port ? s1_read  : s0_read;
        sel_write      = gnt_port ? s1_write : s0_write;
        sel_bc         = gnt_port ? s1_burstcount : s0_burstcount;
        sel_bc_eff     = (sel_bc == '0) ? BC_ONE : sel_bc;
        m_write        = gnt_valid & sel_write;
        m_read         = gnt_valid & (state == IDLE) & sel_read & ~sel_write;
        m_address      = gnt_port ? s1_address    : s0_address;
        m_burstcount   = sel_bc;
        m_writedata    = gnt_port ? s1_writedata  : s0_writedata;
        m_byteenable   = gnt_port ? s1_byteenable : s0_byteenable;
        s0_waitrequest = (gnt_valid && !gnt_port) ? m_waitrequest : 1'b1;
        s1_waitrequest = (gnt_valid &&  gnt_port) ? m_waitrequest : 1'b1;
        accept         = (m_read | m_write) & ~m_waitrequest;
        push           = accept & m_read;
        pop            = route_valid & ((rd_cnt + BC_ONE) == head_bc);
    end

    // Next-state: multi-beat writes lock the grant; last_grant moves only
    // once a transaction (single read/write or final burst beat) completes.
    always_comb begin
        state_nxt      = state;
        wr_left_nxt    = wr_left;
        wr_owner_nxt   = wr_owner;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (m_write && (sel_bc_eff > BC_ONE)) begin
                        state_nxt    = WR_BURST;
                        wr_left_nxt  = sel_bc_eff - BC_ONE;
                        wr_owner_nxt = gnt_port;
                    end else begin
                        last_grant_nxt = gnt_port;
                    end
                end
            end
            WR_BURST: begin
                if (accept) begin
                    wr_left_nxt = wr_left - BC_ONE;
                    if (wr_left == BC_ONE) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = wr_owner;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register for arbitration and burst tracking
    always_ff @(posedge mem_clk) begin
        if (!mem_rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wr_owner   <= 1'b0;
            wr_left    <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wr_owner   <= wr_owner_nxt;
            wr_left    <= wr_left_nxt;
        end
    end

    // Tag storage; contents are only meaningful below fifo_cnt, so no reset
    always_ff @(posedge mem_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {gnt_port, sel_bc_eff};
        end
    end

    // Tag FIFO pointers, occupancy and per-burst beat counter
    always_ff @(posedge mem_clk) begin
        if (!mem_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            rd_cnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                rd_cnt <= '0;
            end else if (route_valid) begin
                rd_cnt <= rd_cnt + BC_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Read return: register EMIF data toward the port owning the FIFO head
    always_ff @(posedge mem_clk) begin
        if (!mem_rst_n) begin
            s0_readdatavalid <= 1'b0;
            s1_readdatavalid <= 1'b0;
            s0_readdata      <= '0;
            s1_readdata      <= '0;
        end else begin
            s0_readdatavalid <= route_valid & ~head_port;
            s1_readdatavalid <= route_valid &  head_port;
            if (route_valid && !head_port) begin
                s0_readdata <= m_readdata;
            end
            if (route_valid && head_port) begin
                s1_readdata <= m_readdata;
            end
        end
    end

`ifdef EMIF_ARB_RD_ERR_CHK_EN
    logic err_q;

    // Sticky flag for read data that has no recorded owner
    always_ff @(posedge mem_clk) begin
        if (!mem_rst_n) begin
            err_q <= 1'b0;
        end else if (m_readdatavalid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_rd_unexp = err_q;

    // Simulation checks for orphan read data and illegal read+write
    always_ff @(posedge mem_clk) begin
        if (mem_rst_n) begin
            assert (!(m_readdatavalid && fifo_empty))
                else $warning("emif_avmm_arb: read data with no owner");
            assert (!(s0_read && s0_write))
                else $warning("emif_avmm_arb: s0 read and write together");
            assert (!(s1_read && s1_write))
                else $warning("emif_avmm_arb: s1 read and write together");
        end
    end
`else
    assign err_rd_unexp = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ofs_fim_emif_avmm_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ofs_fim_emif_avmm_arb
//  Description : Self-checking bench for the EMIF AVMM round-robin arbiter:
//                table of single-cycle grant vectors plus directed
//                multi-cycle sequences (read ordering, write burst lock,
//                FIFO full, burst routing, orphan data, reset mid-burst).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ofs_fim_emif_avmm_arb;

    localparam int AW  = 27;
    localparam int DW  = 32;
    localparam int BCW = 7;
    localparam int BEW = 4;

`ifdef EMIF_ARB_RD_ERR_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic           mem_clk = 1'b0;
    logic           mem_rst_n;
    logic           s0_read, s0_write, s1_read, s1_write;
    logic [AW-1:0]  s0_address, s1_address;
    logic [BCW-1:0] s0_burstcount, s1_burstcount;
    logic [DW-1:0]  s0_writedata, s1_writedata;
    logic [BEW-1:0] s0_byteenable, s1_byteenable;
    logic           s0_waitrequest, s1_waitrequest;
    logic [DW-1:0]  s0_readdata, s1_readdata;
    logic           s0_readdatavalid, s1_readdatavalid;
    logic           m_read, m_write;
    logic [AW-1:0]  m_address;
    logic [BCW-1:0] m_burstcount;
    logic [DW-1:0]  m_writedata;
    logic [BEW-1:0] m_byteenable;
    logic           m_waitrequest;
    logic [DW-1:0]  m_readdata;
    logic           m_readdatavalid;
    logic           err_rd_unexp;

    int checks = 0;
    int errors = 0;

    always #5 mem_clk = ~mem_clk;

    ofs_fim_emif_avmm_arb #(
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH       (DW),
        .BURSTCOUNT_WIDTH (BCW),
        .BYTEENABLE_WIDTH (BEW),
        .RD_FIFO_DEPTH    (16)
    ) dut (
        .mem_clk          (mem_clk),
        .mem_rst_n        (mem_rst_n),
        .s0_read          (s0_read),
        .s0_write         (s0_write),
        .s0_address       (s0_address),
        .s0_burstcount    (s0_burstcount),
        .s0_writedata     (s0_writedata),
        .s0_byteenable    (s0_byteenable),
        .s0_waitrequest   (s0_waitrequest),
        .s0_readdata      (s0_readdata),
        .s0_readdatavalid (s0_readdatavalid),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_address       (s1_address),
        .s1_burstcount    (s1_burstcount),
        .s1_writedata     (s1_writedata),
        .s1_byteenable    (s1_byteenable),
        .s1_waitrequest   (s1_waitrequest),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .m_read           (m_read),
        .m_write          (m_write),
        .m_address        (m_address),
        .m_burstcount     (m_burstcount),
        .m_writedata      (m_writedata),
        .m_byteenable     (m_byteenable),
        .m_waitrequest    (m_waitrequest),
        .m_readdata       (m_readdata),
        .m_readdatavalid  (m_readdatavalid),
        .err_rd_unexp     (err_rd_unexp)
    );

    typedef struct {
        logic          s0r, s0w, s1r, s1w, mw;
        logic          e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic          e_w0, e_w1;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic clear_inputs();
        s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
        s0_address = '0; s1_address = '0;
        s0_burstcount = 7'd1; s1_burstcount = 7'd1;
        s0_writedata = '0; s1_writedata = '0;
        s0_byteenable = '1; s1_byteenable = '1;
        m_waitrequest = 0; m_readdata = '0; m_readdatavalid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        mem_rst_n = 0;
        step();
        step();
        mem_rst_n = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // s0r s0w s1r s1w mw | rd wr addr w0 w1
        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 27'h00, 1, 1};
        vecs[1] = '{1, 0, 0, 0, 0, 1, 0, 27'h10, 0, 1};
        vecs[2] = '{0, 0, 1, 0, 0, 1, 0, 27'h20, 1, 0};
        vecs[3] = '{1, 0, 1, 0, 0, 1, 0, 27'h10, 0, 1};
        vecs[4] = '{1, 0, 1, 0, 1, 1, 0, 27'h10, 1, 1};
        vecs[5] = '{0, 1, 1, 0, 0, 0, 1, 27'h10, 0, 1};
        vecs[6] = '{1, 1, 0, 0, 0, 0, 1, 27'h10, 0, 1};
        vecs[7] = '{0, 0, 0, 1, 0, 0, 1, 27'h20, 1, 0};

        mem_rst_n = 0;
        clear_inputs();
        do_reset();
        check("rst_s0_rdv",  64'(s0_readdatavalid), 0);
        check("rst_s1_rdv",  64'(s1_readdatavalid), 0);
        check("rst_s0_rdata", 64'(s0_readdata), 0);
        check("rst_err",     64'(err_rd_unexp), 0);

        // ---- table: grant selection from a freshly reset arbiter ----
        for (int i = 0; i < 8; i++) begin
            do_reset();
            s0_address = 27'h10; s1_address = 27'h20;
            s0_read = vecs[i].s0r; s0_write = vecs[i].s0w;
            s1_read = vecs[i].s1r; s1_write = vecs[i].s1w;
            m_waitrequest = vecs[i].mw;
            #1;
            check($sformatf("v%0d_m_read", i),  64'(m_read),  64'(vecs[i].e_rd));
            check($sformatf("v%0d_m_write", i), 64'(m_write), 64'(vecs[i].e_wr));
            if (vecs[i].e_rd || vecs[i].e_wr)
                check($sformatf("v%0d_m_addr", i), 64'(m_address), 64'(vecs[i].e_addr));
            check($sformatf("v%0d_s0_wait", i), 64'(s0_waitrequest), 64'(vecs[i].e_w0));
            check($sformatf("v%0d_s1_wait", i), 64'(s1_waitrequest), 64'(vecs[i].e_w1));
        end

        // ---- two reads tie, then in-order return ----
        do_reset();
        s0_read = 1; s0_address = 27'h10;
        s1_read = 1; s1_address = 27'h20;
        #1;
        check("rr_c0_addr", 64'(m_address), 64'h10);
        check("rr_c0_w0",   64'(s0_waitrequest), 0);
        step();
        s0_read = 0;
        #1;
        check("rr_c1_read", 64'(m_read), 1);
        check("rr_c1_addr", 64'(m_address), 64'h20);
        check("rr_c1_w1",   64'(s1_waitrequest), 0);
        step();
        s1_read = 0;
        m_readdatavalid = 1; m_readdata = 32'hD0D0_0000;
        #1;
        check("rr_pre_rdv0", 64'(s0_readdatavalid), 0);
        step();
        m_readdata = 32'hD1D1_1111;
        #1;
        check("rr_d0_rdv0", 64'(s0_readdatavalid), 1);
        check("rr_d0_rdv1", 64'(s1_readdatavalid), 0);
        check("rr_d0_data", 64'(s0_readdata), 64'hD0D0_0000);
        step();
        m_readdatavalid = 0;
        #1;
        check("rr_d1_rdv1", 64'(s1_readdatavalid), 1);
        check("rr_d1_rdv0", 64'(s0_readdatavalid), 0);
        check("rr_d1_data", 64'(s1_readdata), 64'hD1D1_1111);
        step();
        check("rr_idle_rdv1", 64'(s1_readdatavalid), 0);

        // ---- s1 write burst of 4 with a 2-cycle gap; s0 read waits ----
        do_reset();
        s1_write = 1; s1_address = 27'h40; s1_burstcount = 7'd4; s1_writedata = 32'hB1;
        #1;
        check("wb_b1_write", 64'(m_write), 1);
        check("wb_b1_addr",  64'(m_address), 64'h40);
        check("wb_b1_w1",    64'(s1_waitrequest), 0);
        step();
        s1_writedata = 32'hB2;
        s0_read = 1; s0_address = 27'h10;
        #1;
        check("wb_b2_wdata", 64'(m_writedata), 64'hB2);
        check("wb_b2_w0",    64'(s0_waitrequest), 1);
        check("wb_b2_mread", 64'(m_read), 0);
        for (int g = 0; g < 2; g++) begin
            step();
            s1_write = 0;
            #1;
            check($sformatf("wb_gap%0d_write", g), 64'(m_write), 0);
            check($sformatf("wb_gap%0d_w0", g),    64'(s0_waitrequest), 1);
        end
        step();
        s1_write = 1; s1_writedata = 32'hB3;
        #1;
        check("wb_b3_wdata", 64'(m_writedata), 64'hB3);
        step();
        s1_writedata = 32'hB4;
        #1;
        check("wb_b4_write", 64'(m_write), 1);
        check("wb_b4_w0",    64'(s0_waitrequest), 1);
        step();
        s1_write = 0;
        #1;
        check("wb_rd_issue", 64'(m_read), 1);
        check("wb_rd_addr",  64'(m_address), 64'h10);
        check("wb_rd_w0",    64'(s0_waitrequest), 0);
        step();
        s0_read = 0;

        // ---- fill the 16-entry read FIFO, 17th read stalls ----
        do_reset();
        s0_read = 1; s0_address = 27'h80;
        for (int k = 0; k < 16; k++) begin
            #1;
            check($sformatf("full_acc%0d", k), 64'(s0_waitrequest), 0);
            step();
        end
        #1;
        check("full_w0",    64'(s0_waitrequest), 1);
        check("full_mread", 64'(m_read), 0);
        m_readdatavalid = 1;
        #1;
        check("full_pop_w0", 64'(s0_waitrequest), 1);
        step();
        m_readdatavalid = 0;
        #1;
        check("full_17_w0",    64'(s0_waitrequest), 0);
        check("full_17_mread", 64'(m_read), 1);
        step();
        s0_read = 0;

        // ---- s0 burst of 3 then s1 burst of 2: no cross-routing ----
        do_reset();
        s0_read = 1; s0_address = 27'h10; s0_burstcount = 7'd3;
        s1_read = 1; s1_address = 27'h20; s1_burstcount = 7'd2;
        step();
        s0_read = 0;
        step();
        s1_read = 0;
        for (int b = 0; b < 5; b++) begin
            m_readdatavalid = 1; m_readdata = 32'hA0 + b;
            step();
            check($sformatf("rb%0d_rdv0", b), 64'(s0_readdatavalid), (b < 3) ? 1 : 0);
            check($sformatf("rb%0d_rdv1", b), 64'(s1_readdatavalid), (b < 3) ? 0 : 1);
            check($sformatf("rb%0d_data", b), 64'((b < 3) ? s0_readdata : s1_readdata), 64'(32'hA0 + b));
        end
        m_readdatavalid = 0;
        step();
        check("rb_end_rdv0", 64'(s0_readdatavalid), 0);
        check("rb_end_rdv1", 64'(s1_readdatavalid), 0);

        // ---- read data with no owner ----
        do_reset();
        m_readdatavalid = 1; m_readdata = 32'hDEAD;
        step();
        m_readdatavalid = 0;
        check("orph_rdv0", 64'(s0_readdatavalid), 0);
        check("orph_rdv1", 64'(s1_readdatavalid), 0);
        check("orph_err",  64'(err_rd_unexp), 64'(EXP_ERR));
        step();
        step();
        check("orph_err_hold", 64'(err_rd_unexp), 64'(EXP_ERR));
        mem_rst_n = 0;
        step();
        mem_rst_n = 1;
        check("orph_err_clr", 64'(err_rd_unexp), 0);

        // ---- reset during a write burst with two beats left ----
        do_reset();
        s0_write = 1; s0_address = 27'h60; s0_burstcount = 7'd4;
        step();
        step();
        s0_write = 0;
        mem_rst_n = 0;
        step();
        mem_rst_n = 1;
        #1;
        check("rstb_write", 64'(m_write), 0);
        check("rstb_w0",    64'(s0_waitrequest), 1);
        check("rstb_w1",    64'(s1_waitrequest), 1);
        s0_read = 1; s0_address = 27'h10;
        s1_read = 1; s1_address = 27'h20;
        #1;
        check("rstb_tie_read", 64'(m_read), 1);
        check("rstb_tie_addr", 64'(m_address), 64'h10);
        check("rstb_tie_w1",   64'(s1_waitrequest), 1);
        step();
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
